redmule_tcdm_responder: RTL
===========================

// Module: redmule_tcdm_responder
// PURPOSE
//  Responder (slave) end of the HCI core TCDM protocol that the streamer's load/store mux drives as initiator.
//  Serves one wide port against a local 32-bit-word memory: grants requests, performs byte-enabled writes, returns reads.
//  Each wide access covers DW/32 consecutive words. Reads return in order through a small response queue honouring lrdy.
//  Used as a synthesizable local scratch bank and as the bench memory for streamer/engine verification.
// PARAMETERS
//  DW           288   data width in bits; multiple of 32
//  AW           32    byte address width
//  UW           1     user sideband width
//  NB_WORDS     512   memory depth in 32-bit words; power of 2, >= DW/32
//  BASE_ADDR    0     byte address of word 0
//  STALL_PERIOD 0     0: never stall; N>0: every Nth requesting cycle has gnt forced low
//  RESP_DEPTH   2     read response queue depth, >= 1
// PORTS
//  clk_i      in   1      clock
//  rst_i      in   1      asynchronous reset, active-high
//  clear_i    in   1      synchronous clear: flush queue, stall counter, err_o (memory kept)
//  req_i      in   1      request valid
//  gnt_o      out  1      request accepted this cycle
//  add_i      in   AW     byte address; bits [1:0] ignored
//  wen_i      in   1      1 = read, 0 = write
//  data_i     in   DW     write data
//  be_i       in   DW/8   byte enables
//  user_i     in   UW     user sideband, echoed on read response
//  r_data_o   out  DW     read data
//  r_valid_o  out  1      read response valid
//  r_user_o   out  UW     echoed user_i of the request
//  r_opc_o    out  1      1 = response to an out-of-range read
//  lrdy_i     in   1      initiator ready for response
//  err_o      out  1      sticky: any out-of-range access granted
// BEHAVIOUR
//  Reset (rst_i high, async): gnt_o=0, r_valid_o=0, r_data_o=0, r_user_o=0, r_opc_o=0, err_o=0; queue empty; stall counter 0; memory not reset.
//  Addressing: idx = (add_i - BASE_ADDR) >> 2. Lane k (0..DW/32-1) maps to word (idx+k) mod NB_WORDS using bits data[32k+:32] / be[4k+:4].
//  Range: valid iff BASE_ADDR <= add_i < BASE_ADDR + 4*NB_WORDS; checks the start word only, so lanes may wrap modulo depth.
//  Stall counter: counts cycles with req_i=1 and the queue not blocking. stall = (STALL_PERIOD != 0) && (cnt == STALL_PERIOD-1).
//    The counter wraps to 0 after STALL_PERIOD-1.
//  gnt_o (combinational) = req_i & ~stall & (wen_i==0 | queue has a free slot | queue pops this cycle).
//  Write grant: lanes with any be bit set update the enabled bytes at the clock edge. No response is produced.
//    An out-of-range write is dropped and sets err_o.
//  Read grant: memory read at the edge. The entry {data, user_i, opc} is pushed and becomes visible one cycle later (latency 1 when empty).
//    An out-of-range read pushes data=0, opc=1 and sets err_o.
//  Response: r_*_o present the queue head. r_valid_o = queue non-empty. Pop when r_valid_o & lrdy_i.
//    While lrdy_i=0 the head and r_* are held stable.
//  Read-after-write to the same word in consecutive cycles returns the new data (write completes at edge N, read sampled at edge N+1).
//  Write and pop in the same cycle are independent. Read grant with a full queue is allowed only if a pop occurs that cycle.
//  clear_i: queue emptied, r_valid_o=0 next cycle, stall counter=0, err_o=0. gnt_o is forced 0 during the clear cycle.
//  Reset mid-transfer drops queued responses; the initiator must also be reset.
// TESTING
//  1 Write add=0x0, be=all 1s, data=pattern P; read add=0x0 -> gnt same cycle, r_valid 1 cycle later, r_data=P, r_opc=0.
//  2 Partial be: write 0xFFFF... then be lane0=4'b0011, data lane0=0x0000_1234 -> read lane0=0xFFFF_1234, other lanes 0xFFFFFFFF.
//  3 Wrap: NB_WORDS=512, DW=288, write at idx 508 -> lanes 4..8 land in words 0..4; reading idx 0 returns lanes 4..8 as lanes 0..4.
//  4 Backpressure: lrdy=0, issue 3 back-to-back reads (RESP_DEPTH=2) -> 2 granted, 3rd gnt=0; set lrdy=1 -> in-order data, 3rd granted on the pop cycle.
//  5 STALL_PERIOD=3, continuous reads with lrdy=1 -> gnt pattern 1,1,0,1,1,0; all data correct, user echoed per request.
//  6 Out-of-range read at BASE_ADDR+4*NB_WORDS -> r_data=0, r_opc=1, err_o=1 until clear_i; async rst_i mid-burst -> r_valid_o=0 immediately.

Source files
------------

// File: rtl/redmule_tcdm_responder.sv
`default_nettype none
//==============================================================================
// Module   : redmule_tcdm_responder
// Brief    : Responder end of the HCI core TCDM protocol. One wide port is served
//            against a local 32-bit-word memory with byte-enabled writes and
//            in-order read responses through a small queue that honours lrdy_i.
// Revision : 1.0 - initial release
//==============================================================================
module redmule_tcdm_responder #(
    parameter int unsigned   DW           = 288,
    parameter int unsigned   AW           = 32,
    parameter int unsigned   UW           = 1,
    parameter int unsigned   NB_WORDS     = 512,
    parameter logic [AW-1:0] BASE_ADDR    = '0,
    parameter int unsigned   STALL_PERIOD = 0,
    parameter int unsigned   RESP_DEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [AW-1:0]   add_i,
    input  logic            wen_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [UW-1:0]   user_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_valid_o,
    output logic [UW-1:0]   r_user_o,
    output logic            r_opc_o,
    input  logic            lrdy_i,
    output logic            err_o
);

    localparam int unsigned c_LANES   = DW / 32;
    localparam int unsigned c_IDX_W   = $clog2(NB_WORDS);
    localparam int unsigned c_PTR_W   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned c_CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int unsigned c_STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [AW:0] c_SPAN    = (AW+1)'(4 * NB_WORDS);

    logic [31:0]          r_mem [NB_WORDS];
    logic [DW-1:0]        r_q_data [RESP_DEPTH];
    logic [UW-1:0]        r_q_user [RESP_DEPTH];
    logic                 r_q_opc  [RESP_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_err;

    logic [AW-1:0]        w_offset;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_in_range;
    logic                 w_valid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_wr_en;
    logic                 w_not_blocked;
    logic                 w_stall;
    logic [DW-1:0]        w_rd_data;

    // Start-word decode; only the first lane is range-checked, later lanes wrap.
    assign w_offset   = add_i - BASE_ADDR;
    assign w_idx      = w_offset[c_IDX_W+1:2];
    assign w_in_range = (add_i >= BASE_ADDR) && ({1'b0, w_offset} < c_SPAN);

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_CNT_W'(RESP_DEPTH));
    assign w_pop   = w_valid & lrdy_i;

    // A read needs a slot, but a slot freed by this cycle's pop counts as free.
    assign w_not_blocked = ~wen_i | ~w_full | w_pop;
    assign w_stall       = (STALL_PERIOD != 0) && (r_stall_cnt == c_STALL_W'(STALL_PERIOD - 1));

    assign gnt_o   = ~rst_i & ~clear_i & req_i & ~w_stall & w_not_blocked;
    assign w_push  = gnt_o & wen_i;
    assign w_wr_en = gnt_o & ~wen_i & w_in_range;

    // Gather the lanes of a wide read; out-of-range reads return zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < c_LANES; k++) begin
            w_rd_data[32*k +: 32] = w_in_range ? r_mem[w_idx + c_IDX_W'(k)] : 32'h0;
        end
    end

    // Byte-enabled write of every lane, wrapping modulo the memory depth.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int k = 0; k < c_LANES; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[4*k+b]) begin
                        r_mem[w_idx + c_IDX_W'(k)][8*b +: 8] <= data_i[32*k + 8*b +: 8];
                    end
                end
            end
        end
    end

    // Response payload storage; validity is tracked by the control pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_data[r_wptr] <= w_rd_data;
            r_q_user[r_wptr] <= user_i;
            r_q_opc[r_wptr]  <= ~w_in_range;
        end
    end

    // Response queue pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Stall counter advances on every requesting cycle the queue does not block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (clear_i) begin
            r_stall_cnt <= '0;
        end else if ((STALL_PERIOD != 0) && req_i && w_not_blocked) begin
            r_stall_cnt <= w_stall ? '0 : r_stall_cnt + 1'b1;
        end
    end

    // Sticky error flag for any granted out-of-range access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (clear_i) begin
            r_err <= 1'b0;
        end else if (gnt_o && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    // Queue head is presented only while valid so idle outputs read as zero.
    assign r_valid_o = w_valid;
    assign r_data_o  = w_valid ? r_q_data[r_rptr] : '0;
    assign r_user_o  = w_valid ? r_q_user[r_rptr] : '0;
    assign r_opc_o   = w_valid ? r_q_opc[r_rptr]  : 1'b0;
    assign err_o     = r_err;

endmodule
`default_nettype wire
